hack_data_mem: RTL and testbench

Data-memory responder for the Hack CPU's M-bus (`addressM`/`outM`/`writeM`/`inM`). It decodes the 15-bit word address into three regions: general RAM, a single display output register, and a read-only keyboard port. It sits beside the CPU in the top level and replaces any bench-side memory model. Writes are committed on the clock edge; reads are combinational so that same-cycle `M` operands (`M=M+1`, `M=D-M`) complete in one instruction.

---
 rtl/hack_data_mem.sv | 107 ++++++++++
 tb/tb_hack_data_mem.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_mem.sv
// hack_data_mem
// Data-memory responder for the Hack CPU M-bus. The 15-bit word address
// selects general RAM (0 .. RAM_WORDS-1), one display output register at
// DISP_ADDR, or a read-only keyboard port at KBD_ADDR. Every other address
// is unmapped.
// Reads are combinational, so an instruction such as M=M+1 sees the old
// value in the same cycle. Writes commit on the rising clock edge.
//
// Ports:
//   clk       in   1   system clock; all state updates on the rising edge
//   reset     in   1   synchronous active-high reset
//   addressM  in  15   CPU data address
//   outM      in  16   CPU write data
//   writeM    in   1   CPU write strobe for outM at addressM
//   inM       out 16   combinational read data for addressM
//   kbd       in  16   raw keyboard scan code, asynchronous to clk
//   display   out 16   display register contents
//   err       out  1   sticky bus-error flag (bad write), cleared by reset
module hack_data_mem #(
    parameter int          RAM_WORDS = 16384,
    parameter logic [14:0] DISP_ADDR = 15'h4000,
    parameter logic [14:0] KBD_ADDR  = 15'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] kbd,
    output logic [15:0] display,
    output logic        err
);

    // At least one index bit, so that RAM_WORDS=1 still elaborates.
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [15:0] mem_q [RAM_WORDS];

    logic [15:0] display_q, display_d;
    logic        err_q, err_d;
    logic [15:0] kbd_s1_q, kbd_s2_q;

    logic          sel_ram, sel_disp, sel_kbd;
    logic [AW-1:0] ram_idx;

    // Fixed-priority decode: RAM first, then display, then keyboard.
    always_comb begin
        sel_ram  = ({17'd0, addressM} < RAM_WORDS);
        sel_disp = !sel_ram && (addressM == DISP_ADDR);
        sel_kbd  = !sel_ram && !sel_disp && (addressM == KBD_ADDR);
        ram_idx  = addressM[AW-1:0];
    end

    // Combinational read mux. Unmapped addresses read as zero.
    always_comb begin
        inM = 16'h0000;
        if (sel_ram) begin
            inM = mem_q[ram_idx];
        end else if (sel_disp) begin
            inM = display_q;
        end else if (sel_kbd) begin
            inM = kbd_s2_q;
        end
    end

    // Next-state for the display register and the sticky error flag.
    // A write that lands on the keyboard or an unmapped address sets err.
    always_comb begin
        display_d = display_q;
        err_d     = err_q;
        if (writeM) begin
            if (sel_disp) begin
                display_d = outM;
            end else if (!sel_ram) begin
                err_d = 1'b1;
            end
        end
    end

    // RAM has no reset so that it maps onto block memory; reset only
    // blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && writeM && sel_ram) begin
            mem_q[ram_idx] <= outM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display_q <= 16'h0000;
            err_q     <= 1'b0;
            kbd_s1_q  <= 16'h0000;
            kbd_s2_q  <= 16'h0000;
        end else begin
            display_q <= display_d;
            err_q     <= err_d;
            // Two-flop synchronizer for the asynchronous keyboard input.
            kbd_s1_q  <= kbd;
            kbd_s2_q  <= kbd_s1_q;
        end
    end

    assign display = display_q;
    assign err     = err_q;

endmodule

// File: tb/tb_hack_data_mem.sv
module tb_hack_data_mem;

    logic        clk;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] kbd;
    logic [15:0] display;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hack_data_mem dut (
        .clk      (clk),
        .reset    (reset),
        .addressM (addressM),
        .outM     (outM),
        .writeM   (writeM),
        .inM      (inM),
        .kbd      (kbd),
        .display  (display),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write cycle: inputs change on the falling edge, committed at the
    // next rising edge, strobe dropped 1 time unit later.
    task automatic do_write(input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        @(posedge clk);
        #1;
        writeM   = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    // Present a read address away from the clock edge.
    task automatic set_addr(input logic [14:0] a);
        @(negedge clk);
        addressM = a;
        writeM   = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset  = 1'b1;
        writeM = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        addressM = 15'h0000;
        outM     = 16'h0000;
        writeM   = 1'b0;
        kbd      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total_cnt++;
        if (display !== 16'h0000) $display("FAIL reset_display got=%h exp=0000", display);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err);
        else pass_cnt++;
        set_addr(15'h4000);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL reset_rd_disp got=%h exp=0000", inM);
        else pass_cnt++;
        set_addr(15'h6000);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL reset_rd_kbd got=%h exp=0000", inM);
        else pass_cnt++;
        set_addr(15'h5000);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL reset_rd_unmapped got=%h exp=0000", inM);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_ram_rw();
        do_write(15'h1234, 16'h2345);
        do_write(15'h0005, 16'hDCBA);
        set_addr(15'h1234);
        total_cnt++;
        if (inM !== 16'h2345) $display("FAIL ram_rd_1234 got=%h exp=2345", inM);
        else pass_cnt++;
        set_addr(15'h0005);
        total_cnt++;
        if (inM !== 16'hDCBA) $display("FAIL ram_rd_0005 got=%h exp=DCBA", inM);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL ram_err got=%b exp=0", err);
        else pass_cnt++;
        // Top RAM word boundary.
        do_write(15'h3FFF, 16'h0F0F);
        set_addr(15'h3FFF);
        total_cnt++;
        if (inM !== 16'h0F0F) $display("FAIL ram_rd_3fff got=%h exp=0F0F", inM);
        else pass_cnt++;
        $display("test_ram_rw done");
    endtask

    task automatic test_rmw();
        do_write(15'h1234, 16'h1234);
        // M=M+1 in one cycle.
        @(negedge clk);
        addressM = 15'h1234;
        writeM   = 1'b1;
        #1;
        total_cnt++;
        if (inM !== 16'h1234) $display("FAIL rmw_inc_old got=%h exp=1234", inM);
        else pass_cnt++;
        outM = inM + 16'd1;
        @(posedge clk);
        #1;
        writeM = 1'b0;
        total_cnt++;
        if (inM !== 16'h1235) $display("FAIL rmw_inc_new got=%h exp=1235", inM);
        else pass_cnt++;
        // M=!M twice: 1235 -> EDCA -> 1235.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            writeM = 1'b1;
            #1;
            outM = ~inM;
            @(posedge clk);
            #1;
            writeM = 1'b0;
            total_cnt++;
            if (i == 0 && inM !== 16'hEDCA) $display("FAIL rmw_not got=%h exp=EDCA", inM);
            else if (i == 1 && inM !== 16'h1235) $display("FAIL rmw_not2 got=%h exp=1235", inM);
            else pass_cnt++;
        end
        $display("test_rmw done");
    endtask

    task automatic test_display();
        do_write(15'h4000, 16'h3375);
        total_cnt++;
        if (display !== 16'h3375) $display("FAIL disp_out got=%h exp=3375", display);
        else pass_cnt++;
        set_addr(15'h4000);
        total_cnt++;
        if (inM !== 16'h3375) $display("FAIL disp_rd got=%h exp=3375", inM);
        else pass_cnt++;
        pulse_reset();
        total_cnt++;
        if (display !== 16'h0000) $display("FAIL disp_reset got=%h exp=0000", display);
        else pass_cnt++;
        set_addr(15'h1234);
        total_cnt++;
        if (inM !== 16'h1235) $display("FAIL ram_keep_reset got=%h exp=1235", inM);
        else pass_cnt++;
        $display("test_display done");
    endtask

    task automatic test_keyboard();
        @(negedge clk);
        kbd      = 16'h0041;
        addressM = 15'h6000;
        @(posedge clk);
        #1;
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL kbd_edge1 got=%h exp=0000", inM);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (inM !== 16'h0041) $display("FAIL kbd_edge2 got=%h exp=0041", inM);
        else pass_cnt++;
        do_write(15'h6000, 16'hFFFF);
        set_addr(15'h6000);
        total_cnt++;
        if (inM !== 16'h0041) $display("FAIL kbd_wr_ignored got=%h exp=0041", inM);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL kbd_wr_err got=%b exp=1", err);
        else pass_cnt++;
        $display("test_keyboard done");
    endtask

    task automatic test_unmapped();
        pulse_reset();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_cleared got=%b exp=0", err);
        else pass_cnt++;
        set_addr(15'h5000);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL unm_rd got=%h exp=0000", inM);
        else pass_cnt++;
        do_write(15'h5000, 16'hBEEF);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL unm_err got=%b exp=1", err);
        else pass_cnt++;
        set_addr(15'h5000);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL unm_rd_after got=%h exp=0000", inM);
        else pass_cnt++;
        set_addr(15'h7FFF);
        total_cnt++;
        if (inM !== 16'h0000) $display("FAIL unm_rd_7fff got=%h exp=0000", inM);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err);
        else pass_cnt++;
        pulse_reset();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL err_reset got=%b exp=0", err);
        else pass_cnt++;
        $display("test_unmapped done");
    endtask

    task automatic test_reset_vs_write();
        do_write(15'h0007, 16'h1111);
        do_write(15'h4000, 16'h9999);
        @(negedge clk);
        reset    = 1'b1;
        addressM = 15'h0007;
        outM     = 16'hAAAA;
        writeM   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addressM = 15'h4000;
        outM     = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        writeM = 1'b0;
        total_cnt++;
        if (display !== 16'h0000) $display("FAIL rst_wr_disp got=%h exp=0000", display);
        else pass_cnt++;
        set_addr(15'h0007);
        total_cnt++;
        if (inM !== 16'h1111) $display("FAIL rst_wr_ram got=%h exp=1111", inM);
        else pass_cnt++;
        $display("test_reset_vs_write done");
    endtask

    task automatic test_back_to_back();
        do_write(15'h0010, 16'h1111);
        do_write(15'h0010, 16'h2222);
        set_addr(15'h0010);
        total_cnt++;
        if (inM !== 16'h2222) $display("FAIL b2b_ram got=%h exp=2222", inM);
        else pass_cnt++;
        do_write(15'h4000, 16'hA1A1);
        do_write(15'h4000, 16'hB2B2);
        total_cnt++;
        if (display !== 16'hB2B2) $display("FAIL b2b_disp got=%h exp=B2B2", display);
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_rmw();
        test_display();
        test_keyboard();
        test_unmapped();
        test_reset_vs_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
